display_buf: RTL and testbench

CPU-to-terminal output path; the transmit counterpart of the keyboard input buffer.
- CPU writes 7-bit ASCII characters into a FIFO.
- An internal UART serializer drains the FIFO as 8N1 frames on a single serial line.
- Sits between the Y86 memory-mapped I/O decode (display data/status registers) and the board's UART TX pin.

---
 rtl/display_pkg.sv | 17 +
 rtl/uart_tx_serializer.sv | 89 ++++++++
 rtl/display_buf.sv | 123 ++++++++++++
 tb/tb_display_buf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display output path: the serializer
// state encoding, the ASCII characters involved in CR/LF expansion and the frame width.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

  localparam logic [6:0] ASCII_CR = 7'h0D;
  localparam logic [6:0] ASCII_LF = 7'h0A;

  localparam int FRAME_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each bit
// CLKS_PER_BIT clocks wide; tx comes straight from a flop so the line never glitches.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  import display_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    BIT_LAST = 3'(FRAME_DATA_BITS - 1);

  ser_state_t    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);
  // done marks the final clock of the stop bit, i.e. the edge that returns to IDLE
  assign done    = (state == STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift   <= data;
            bit_cnt <= '0;
            clk_cnt <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/display_buf.sv
// CPU-to-terminal output buffer: character FIFO drained by a UART serializer.
// Define DISP_CRLF_EN to transmit CR ahead of every LF.
module display_buf #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DISP_write_en,
  input  logic [6:0] DISP_data,
  input  logic       DISP_clear,
  output logic       DISP_status,
  output logic       buf_full,
  output logic       buf_empty,
  output logic       tx_busy,
  output logic       tx
);
  import display_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [6:0]    head;
  logic [6:0]    ser_char;
  logic          push;
  logic          pop;
  logic          start;
  logic          ser_idle;
  logic          ser_done;

  assign head        = mem[rd_ptr];
  assign push        = DISP_write_en && !buf_full && !DISP_clear;
  assign start       = ser_idle && !buf_empty;
  assign DISP_status = ~buf_full;

`ifdef DISP_CRLF_EN
  // An LF at the head first launches a CR frame without popping; cr_sent
  // remembers that so the following launch sends the LF itself and pops it.
  logic cr_sent;
  logic insert_cr;

  assign insert_cr = (head == ASCII_LF) && !cr_sent;
  assign ser_char  = insert_cr ? ASCII_CR : head;
  assign pop       = start && !insert_cr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_sent <= 1'b0;
    end else if (DISP_clear || pop) begin
      cr_sent <= 1'b0;
    end else if (start) begin
      cr_sent <= 1'b1;
    end
  end
`else
  assign ser_char = head;
  assign pop      = start;
`endif

  always_comb begin
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= DISP_data;
    end
  end

  // Clear flushes only queued characters; a frame already launched runs to completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      buf_full  <= 1'b0;
      buf_empty <= 1'b1;
      ser_idle  <= 1'b1;
    end else begin
      if (DISP_clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        buf_full  <= 1'b0;
        buf_empty <= 1'b1;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        count     <= count_next;
        buf_full  <= (count_next == CNT_FULL);
        buf_empty <= (count_next == '0);
      end
      if (start) begin
        ser_idle <= 1'b0;
      end else if (ser_done) begin
        ser_idle <= 1'b1;
      end
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data ({1'b0, ser_char}),
    .tx   (tx),
    .busy (tx_busy),
    .done (ser_done)
  );

endmodule

// File: tb/tb_display_buf.sv
// Directed bench for display_buf with DEPTH=4, CLKS_PER_BIT=4; frames are checked
// cycle by cycle. Define DISP_CRLF_EN here as well as in the RTL for the CR/LF build.
module tb_display_buf;

  logic       clk;
  logic       rst;
  logic       DISP_write_en;
  logic [6:0] DISP_data;
  logic       DISP_clear;
  logic       DISP_status;
  logic       buf_full;
  logic       buf_empty;
  logic       tx_busy;
  logic       tx;

  int assert_count = 0;
  int fail_count   = 0;

  display_buf #(
    .DEPTH(4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .DISP_write_en(DISP_write_en),
    .DISP_data    (DISP_data),
    .DISP_clear   (DISP_clear),
    .DISP_status  (DISP_status),
    .buf_full     (buf_full),
    .buf_empty    (buf_empty),
    .tx_busy      (tx_busy),
    .tx           (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, return at the following falling edge.
  task automatic applyStimulus(input logic we, input logic [6:0] d, input logic clr);
    DISP_write_en = we;
    DISP_data     = d;
    DISP_clear    = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic releaseInputs();
    DISP_write_en = 1'b0;
    DISP_data     = 7'h00;
    DISP_clear    = 1'b0;
  endtask

  // Called at the falling edge of frame cycle start_off (0 = first start-bit cycle);
  // returns at cycle 40, the single IDLE cycle after the stop bit.
  task automatic checkFrame(input string tag, input logic [6:0] ch, input int start_off);
    logic [9:0] fr;
    fr = {1'b1, 1'b0, ch, 1'b0};
    for (int k = start_off; k < 40; k++) begin
      checkOutput($sformatf("%s tx c%0d", tag, k), {7'b0, tx}, {7'b0, fr[k/4]});
      checkOutput($sformatf("%s busy c%0d", tag, k), {7'b0, tx_busy}, 8'h01);
      @(negedge clk);
    end
    checkOutput({tag, " idle tx"}, {7'b0, tx}, 8'h01);
    checkOutput({tag, " idle busy"}, {7'b0, tx_busy}, 8'h00);
  endtask

  task automatic checkQuiet(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s tx q%0d", tag, k), {7'b0, tx}, 8'h01);
      checkOutput($sformatf("%s busy q%0d", tag, k), {7'b0, tx_busy}, 8'h00);
      checkOutput($sformatf("%s empty q%0d", tag, k), {7'b0, buf_empty}, 8'h01);
    end
  endtask

  initial begin
    rst = 1'b1;
    releaseInputs();
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset tx", {7'b0, tx}, 8'h01);
    checkOutput("reset busy", {7'b0, tx_busy}, 8'h00);
    checkOutput("reset empty", {7'b0, buf_empty}, 8'h01);
    checkOutput("reset full", {7'b0, buf_full}, 8'h00);
    checkOutput("reset status", {7'b0, DISP_status}, 8'h01);
    rst = 1'b0;
    @(negedge clk);

    // Single 'h': empty clears after the write edge, pop and tx fall on the next edge
    applyStimulus(1'b1, 7'h68, 1'b0);
    releaseInputs();
    checkOutput("t1 empty after write", {7'b0, buf_empty}, 8'h00);
    checkOutput("t1 tx before pop", {7'b0, tx}, 8'h01);
    checkOutput("t1 busy before pop", {7'b0, tx_busy}, 8'h00);
    @(negedge clk);
    checkOutput("t1 empty after pop", {7'b0, buf_empty}, 8'h01);
    checkFrame("t1 h", 7'h68, 0);
    checkQuiet("t1", 3);

    // Burst "hello" then '!' while full
    applyStimulus(1'b1, 7'h68, 1'b0);
    checkOutput("t2 empty e1", {7'b0, buf_empty}, 8'h00);
    applyStimulus(1'b1, 7'h65, 1'b0);
    checkOutput("t2 tx start", {7'b0, tx}, 8'h00);
    applyStimulus(1'b1, 7'h6C, 1'b0);
    applyStimulus(1'b1, 7'h6C, 1'b0);
    checkOutput("t2 full e4", {7'b0, buf_full}, 8'h00);
    applyStimulus(1'b1, 7'h6F, 1'b0);
    checkOutput("t2 full e5", {7'b0, buf_full}, 8'h01);
    checkOutput("t2 status e5", {7'b0, DISP_status}, 8'h00);
    applyStimulus(1'b1, 7'h21, 1'b0);
    releaseInputs();
    checkOutput("t2 full e6", {7'b0, buf_full}, 8'h01);
    checkFrame("t2 h", 7'h68, 4);
    checkOutput("t2 full at idle", {7'b0, buf_full}, 8'h01);
    @(negedge clk);
    checkOutput("t2 full after pop", {7'b0, buf_full}, 8'h00);
    checkOutput("t2 status after pop", {7'b0, DISP_status}, 8'h01);
    checkFrame("t2 e", 7'h65, 0);
    @(negedge clk);
    checkFrame("t2 l1", 7'h6C, 0);
    @(negedge clk);
    checkFrame("t2 l2", 7'h6C, 0);
    @(negedge clk);
    checkFrame("t2 o", 7'h6F, 0);
    checkQuiet("t2", 6);

    // Overflow: 'X' in flight, then a..f; e and f land on a full FIFO
    applyStimulus(1'b1, 7'h58, 1'b0);
    applyStimulus(1'b1, 7'h61, 1'b0);
    applyStimulus(1'b1, 7'h62, 1'b0);
    applyStimulus(1'b1, 7'h63, 1'b0);
    checkOutput("t3 full at 3", {7'b0, buf_full}, 8'h00);
    applyStimulus(1'b1, 7'h64, 1'b0);
    checkOutput("t3 full at 4", {7'b0, buf_full}, 8'h01);
    checkOutput("t3 status at 4", {7'b0, DISP_status}, 8'h00);
    applyStimulus(1'b1, 7'h65, 1'b0);
    applyStimulus(1'b1, 7'h66, 1'b0);
    releaseInputs();
    checkOutput("t3 full after drops", {7'b0, buf_full}, 8'h01);
    checkFrame("t3 X", 7'h58, 5);
    @(negedge clk);
    checkFrame("t3 a", 7'h61, 0);
    @(negedge clk);
    checkFrame("t3 b", 7'h62, 0);
    @(negedge clk);
    checkFrame("t3 c", 7'h63, 0);
    @(negedge clk);
    checkFrame("t3 d", 7'h64, 0);
    checkQuiet("t3", 6);

    // Clear during 'w' data bits; write on the clear edge is dropped
    applyStimulus(1'b1, 7'h77, 1'b0);
    applyStimulus(1'b1, 7'h6F, 1'b0);
    applyStimulus(1'b1, 7'h72, 1'b0);
    releaseInputs();
    checkOutput("t4 empty before clear", {7'b0, buf_empty}, 8'h00);
    for (int k = 0; k < 5; k++) @(negedge clk);
    applyStimulus(1'b1, 7'h5A, 1'b1);
    releaseInputs();
    checkOutput("t4 empty after clear", {7'b0, buf_empty}, 8'h01);
    checkOutput("t4 status after clear", {7'b0, DISP_status}, 8'h01);
    checkFrame("t4 w", 7'h77, 7);
    checkQuiet("t4", 50);

    // Async reset in the middle of the 0x6C data bits with 'q' still queued
    applyStimulus(1'b1, 7'h6C, 1'b0);
    applyStimulus(1'b1, 7'h71, 1'b0);
    releaseInputs();
    for (int k = 0; k < 10; k++) @(negedge clk);
    checkOutput("t5 tx mid data", {7'b0, tx}, 8'h00);
    checkOutput("t5 empty before rst", {7'b0, buf_empty}, 8'h00);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5 async tx", {7'b0, tx}, 8'h01);
    checkOutput("t5 async busy", {7'b0, tx_busy}, 8'h00);
    checkOutput("t5 async empty", {7'b0, buf_empty}, 8'h01);
    checkOutput("t5 async full", {7'b0, buf_full}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    checkQuiet("t5 post", 2);
    applyStimulus(1'b1, 7'h64, 1'b0);
    releaseInputs();
    checkOutput("t5 empty after write", {7'b0, buf_empty}, 8'h00);
    checkOutput("t5 tx before pop", {7'b0, tx}, 8'h01);
    @(negedge clk);
    checkFrame("t5 d", 7'h64, 0);
    checkQuiet("t5", 3);

    // Line feed
    applyStimulus(1'b1, 7'h0A, 1'b0);
    releaseInputs();
    @(negedge clk);
`ifdef DISP_CRLF_EN
    checkOutput("t6 LF still queued", {7'b0, buf_empty}, 8'h00);
    checkFrame("t6 CR", 7'h0D, 0);
    @(negedge clk);
    checkOutput("t6 LF popped", {7'b0, buf_empty}, 8'h01);
    checkFrame("t6 LF", 7'h0A, 0);
`else
    checkOutput("t6 LF popped", {7'b0, buf_empty}, 8'h01);
    checkFrame("t6 LF", 7'h0A, 0);
`endif
    checkQuiet("t6", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
